// File: rtl/bcd_addsub_serial_if.sv
// ---------------------------------------------------------------------------
// bcd_addsub_serial_if
//   Request/response bundle for the digit-serial BCD adder/subtractor.
//
//   Handshake: the requester raises start together with sub/a/b/cin.  The
//   request is accepted on the first rising edge at which the unit is idle
//   (busy=0).  A start seen while busy=1 is dropped, not queued.  Completion
//   is a single-cycle done pulse, and res/cout/err are valid in that cycle.
//   res/cout/err then hold until the next completion.
//
//   Signals
//     start  master->slave  request strobe
//     sub    master->slave  0 = add, 1 = subtract
//     a, b   master->slave  packed BCD operands, digit 0 in [3:0]
//     cin    master->slave  carry-in (add) or borrow-in (sub)
//     busy   slave->master  operation in flight
//     done   slave->master  one-cycle completion pulse
//     res    slave->master  packed BCD result
//     cout   slave->master  carry-out (add) or borrow-out (sub)
//     err    slave->master  an operand digit was outside 0..9
// ---------------------------------------------------------------------------
interface bcd_addsub_serial_if #(
    parameter int DIGITS = 4
);
    localparam int W = 4 * DIGITS;

    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] res;
    logic         cout;
    logic         err;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, res, cout, err
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, res, cout, err
    );
endinterface

// File: rtl/bcd_addsub_serial.sv
// ---------------------------------------------------------------------------
// bcd_addsub_serial
//   Digit-serial packed-BCD adder/subtractor.  One decimal digit is processed
//   per clock, least significant first, so an operation takes DIGITS cycles
//   from the accepting edge to the done pulse.  Subtraction is done in ten's
//   complement: each B digit is replaced by its nine's complement and the
//   initial carry is the inverted borrow-in.
//
//   Ports
//     clk          rising-edge clock
//     rst          synchronous, active-high reset (wins over start)
//     bus          bcd_addsub_serial_if.slave request/response bundle
//     dbg_state_o  current FSM state (0 = IDLE, 1 = RUN)
// ---------------------------------------------------------------------------
module bcd_addsub_serial #(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    bcd_addsub_serial_if.slave        bus,
    output logic                      dbg_state_o
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic          carry_q, carry_d;
    logic          sub_q,   sub_d;
    logic [W-1:0]  a_q,     a_d;
    logic [W-1:0]  b_q,     b_d;
    logic [W-1:0]  work_q,  work_d;
    logic [W-1:0]  res_q,   res_d;
    logic          cout_q,  cout_d;
    logic          err_q,   err_d;
    logic          done_q,  done_d;

    // Current-digit datapath
    logic [3:0]    a_dig;
    logic [3:0]    b_dig;
    logic [3:0]    bd;
    logic [4:0]    dig_sum;
    logic [3:0]    dig_out;
    logic          dig_carry;
    logic          any_bad;
    logic [W-1:0]  work_upd;

    // -----------------------------------------------------------------------
    // Digit slice: select digit idx_q of both latched operands and form one
    // decimal digit of the sum.  The carry into this digit is always the
    // registered carry of the previous digit, so there is no ripple path.
    // -----------------------------------------------------------------------
    always_comb begin : digit_path
        a_dig    = '0;
        b_dig    = '0;
        work_upd = work_q;
        any_bad  = 1'b0;

        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
            end
        end

        // Nine's complement of B for subtraction.  An invalid B digit wraps
        // here, but err suppresses the result in that case anyway.
        bd      = sub_q ? (4'd9 - b_dig) : b_dig;
        dig_sum = {1'b0, a_dig} + {1'b0, bd} + {4'd0, carry_q};

        if (dig_sum > 5'd9) begin
            dig_out   = 4'(dig_sum - 5'd10);
            dig_carry = 1'b1;
        end else begin
            dig_out   = dig_sum[3:0];
            dig_carry = 1'b0;
        end

        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                work_upd[4*i +: 4] = dig_out;
            end
            if ((a_q[4*i +: 4] > 4'd9) || (b_q[4*i +: 4] > 4'd9)) begin
                any_bad = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (idx_q == LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath next values and completion outputs
    // -----------------------------------------------------------------------
    always_comb begin : output_logic
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        res_d   = res_q;
        cout_d  = cout_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sub_d   = bus.sub;
                    // Ten's complement: A - B - bin = A + (99..9 - B) + 1 - bin
                    carry_d = bus.sub ? ~bus.cin : bus.cin;
                    idx_d   = '0;
                    work_d  = '0;
                end
            end
            RUN: begin
                work_d  = work_upd;
                carry_d = dig_carry;
                if (idx_q == LAST) begin
                    idx_d  = '0;
                    done_d = 1'b1;
                    err_d  = any_bad;
                    if (any_bad) begin
                        res_d  = '0;
                        cout_d = 1'b0;
                    end else begin
                        res_d  = work_upd;
                        // A final carry in subtract mode means "no borrow".
                        cout_d = sub_q ? ~dig_carry : dig_carry;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy    = (state_q == RUN);
    assign bus.done    = done_q;
    assign bus.res     = res_q;
    assign bus.cout    = cout_q;
    assign bus.err     = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// ---------------------------------------------------------------------------
// tb_bcd_addsub_serial
//   Bench for bcd_addsub_serial with DIGITS = 1, 4 and 8 instances.  Expected
//   results ({err, cout, res}) and done cycles are queued when a request is
//   driven and compared when the matching done pulse appears.
// ---------------------------------------------------------------------------
module tb_bcd_addsub_serial;

  // ------------------------------------------------------------ clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ DUTs
  logic st1, st4, st8;

  bcd_addsub_serial_if #(.DIGITS(1)) bus1 ();
  bcd_addsub_serial_if #(.DIGITS(4)) bus4 ();
  bcd_addsub_serial_if #(.DIGITS(8)) bus8 ();

  bcd_addsub_serial #(.DIGITS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1), .dbg_state_o(st1));
  bcd_addsub_serial #(.DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4), .dbg_state_o(st4));
  bcd_addsub_serial #(.DIGITS(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8), .dbg_state_o(st8));

  // ------------------------------------------------------------ scoreboard
  // Expected entry layout: {err, cout, res[31:0]}
  logic [33:0] exp1_q[$];
  logic [33:0] exp4_q[$];
  logic [33:0] exp8_q[$];
  int          due1_q[$];
  int          due4_q[$];
  int          due8_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Decimal reference: converts BCD to integers, does the arithmetic in
  // ordinary integer form and converts back.
  function automatic logic [33:0] model(input int n, input logic [31:0] a, input logic [31:0] b,
                                        input logic s, input logic c);
    longint av = 0, bv = 0, m = 1, r;
    logic   bad = 1'b0;
    logic   co;
    logic [31:0] res = '0;
    logic [3:0]  da, db;
    for (int i = n - 1; i >= 0; i--) begin
      da = a[i*4 +: 4];
      db = b[i*4 +: 4];
      if (da > 4'd9 || db > 4'd9) bad = 1'b1;
      av = av * 10 + longint'(da);
      bv = bv * 10 + longint'(db);
      m  = m * 10;
    end
    if (s) begin
      r  = av - bv - longint'(c);
      co = (r < 0);
      if (r < 0) r = r + m;
    end else begin
      r  = av + bv + longint'(c);
      co = (r >= m);
      if (co) r = r - m;
    end
    for (int i = 0; i < n; i++) begin
      res[i*4 +: 4] = 4'(r % 10);
      r = r / 10;
    end
    if (bad) return {1'b1, 1'b0, 32'h0};
    return {1'b0, co, res};
  endfunction

  function automatic logic [31:0] rand_bcd(input int n, input bit allow_bad);
    logic [31:0] v = '0;
    int j;
    for (int i = 0; i < n; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && $urandom_range(0, 7) == 0) begin
      j = $urandom_range(0, n - 1);
      v[j*4 +: 4] = 4'($urandom_range(10, 15));
    end
    return v;
  endfunction

  // Monitor: every done pulse must match the oldest expectation, on the
  // expected cycle; a done with nothing queued is an error.
  always @(negedge clk) begin
    logic [33:0] e;
    int          t;
    if (bus1.done) begin
      if (exp1_q.size() == 0) check("d1_spurious_done", 64'(bus1.done), 64'd0);
      else begin
        e = exp1_q.pop_front(); t = due1_q.pop_front();
        check("d1_res",  64'(bus1.res),  64'(e[3:0]));
        check("d1_cout", 64'(bus1.cout), 64'(e[32]));
        check("d1_err",  64'(bus1.err),  64'(e[33]));
        check("d1_latency", 64'(cyc), 64'(t));
      end
    end
    if (bus4.done) begin
      if (exp4_q.size() == 0) check("d4_spurious_done", 64'(bus4.done), 64'd0);
      else begin
        e = exp4_q.pop_front(); t = due4_q.pop_front();
        check("d4_res",  64'(bus4.res),  64'(e[15:0]));
        check("d4_cout", 64'(bus4.cout), 64'(e[32]));
        check("d4_err",  64'(bus4.err),  64'(e[33]));
        check("d4_latency", 64'(cyc), 64'(t));
      end
    end
    if (bus8.done) begin
      if (exp8_q.size() == 0) check("d8_spurious_done", 64'(bus8.done), 64'd0);
      else begin
        e = exp8_q.pop_front(); t = due8_q.pop_front();
        check("d8_res",  64'(bus8.res),  64'(e[31:0]));
        check("d8_cout", 64'(bus8.cout), 64'(e[32]));
        check("d8_err",  64'(bus8.err),  64'(e[33]));
        check("d8_latency", 64'(cyc), 64'(t));
      end
    end
  end

  // ------------------------------------------------------------ driver tasks
  // Drives one start pulse on instance `which` (1, 4 or 8 digits); the
  // request is accepted at the next rising edge, done follows `which` edges
  // later.  Returns at the falling edge of the first RUN cycle.
  task automatic drive(input int which, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic c, input bit push, input logic [33:0] e);
    @(negedge clk);
    case (which)
      1: begin
        bus1.start = 1'b1; bus1.a = a[3:0]; bus1.b = b[3:0]; bus1.sub = s; bus1.cin = c;
        if (push) begin exp1_q.push_back(e); due1_q.push_back(cyc + 1 + which); end
      end
      4: begin
        bus4.start = 1'b1; bus4.a = a[15:0]; bus4.b = b[15:0]; bus4.sub = s; bus4.cin = c;
        if (push) begin exp4_q.push_back(e); due4_q.push_back(cyc + 1 + which); end
      end
      default: begin
        bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.sub = s; bus8.cin = c;
        if (push) begin exp8_q.push_back(e); due8_q.push_back(cyc + 1 + which); end
      end
    endcase
    @(negedge clk);
    bus1.start = 1'b0;
    bus4.start = 1'b0;
    bus8.start = 1'b0;
  endtask

  task automatic wait_drain(input int which);
    int left = 0;
    for (int k = 0; k < 60; k++) begin
      case (which)
        1:       left = exp1_q.size();
        4:       left = exp4_q.size();
        default: left = exp8_q.size();
      endcase
      if (left == 0) break;
      @(negedge clk);
    end
    if (left != 0) check("drain_timeout", 64'(left), 64'd0);
  endtask

  // ------------------------------------------------------------ vectors
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] res;
    logic        cout;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int busy_cnt;
    bit seen;
    logic [31:0] ra, rb;
    logic rs, rc;

    vecs[0] = '{16'h1234, 16'h8766, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h0999, 16'h0001, 1'b0, 1'b1, 16'h1001, 1'b0, 1'b0};
    vecs[2] = '{16'h9999, 16'h9999, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[3] = '{16'h0500, 16'h0123, 1'b1, 1'b0, 16'h0377, 1'b0, 1'b0};
    vecs[4] = '{16'h0500, 16'h0123, 1'b1, 1'b1, 16'h0376, 1'b0, 1'b0};
    vecs[5] = '{16'h0123, 16'h0500, 1'b1, 1'b0, 16'h9623, 1'b1, 1'b0};
    vecs[6] = '{16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[7] = '{16'h0042, 16'h0058, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[8] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[9] = '{16'h0007, 16'h00F0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};

    bus1.start = 1'b0; bus1.sub = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    bus4.start = 1'b0; bus4.sub = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    bus8.start = 1'b0; bus8.sub = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;

    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy",  64'(bus4.busy), 64'd0);
    check("rst_done",  64'(bus4.done), 64'd0);
    check("rst_res",   64'(bus4.res),  64'd0);
    check("rst_cout",  64'(bus4.cout), 64'd0);
    check("rst_err",   64'(bus4.err),  64'd0);
    check("rst_state", 64'(st4),       64'd0);
    rst = 1'b0;

    // First add: busy must be high for exactly DIGITS cycles
    drive(4, 32'h1234, 32'h8766, 1'b0, 1'b0, 1'b1, {1'b0, 1'b1, 32'h0000});
    busy_cnt = bus4.busy ? 1 : 0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus4.done) begin seen = 1'b1; break; end
      if (bus4.busy) busy_cnt++;
    end
    check("busy_done_seen", 64'(seen), 64'd1);
    check("busy_cycles", 64'(busy_cnt), 64'd4);
    check("busy_low_at_done", 64'(bus4.busy), 64'd0);
    wait_drain(4);

    // Table-driven vectors
    for (int v = 0; v < 10; v++) begin
      drive(4, {16'h0, vecs[v].a}, {16'h0, vecs[v].b}, vecs[v].sub, vecs[v].cin, 1'b1,
            {vecs[v].err, vecs[v].cout, 16'h0, vecs[v].res});
      wait_drain(4);
    end

    // start pulsed during RUN cycles 1 and 2 is ignored
    drive(4, 32'h2000, 32'h0345, 1'b0, 1'b0, 1'b1, {1'b0, 1'b0, 32'h2345});
    bus4.start = 1'b1; bus4.a = 16'h7777; bus4.b = 16'h1111;
    @(negedge clk);
    @(negedge clk);
    bus4.start = 1'b0;
    wait_drain(4);
    repeat (8) @(negedge clk);

    // start held through the done cycle: second op follows back to back;
    // operand changes after acceptance must not affect the first op.
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 16'h1111; bus4.b = 16'h2222; bus4.sub = 1'b0; bus4.cin = 1'b0;
    exp4_q.push_back({1'b0, 1'b0, 32'h3333}); due4_q.push_back(cyc + 5);
    @(negedge clk);
    bus4.a = 16'h4321; bus4.b = 16'h1234; bus4.sub = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus4.done) begin seen = 1'b1; break; end
    end
    check("b2b_first_done", 64'(seen), 64'd1);
    exp4_q.push_back({1'b0, 1'b0, 32'h3087}); due4_q.push_back(cyc + 5);
    @(negedge clk);
    bus4.start = 1'b0;
    wait_drain(4);
    repeat (6) @(negedge clk);

    // Reset in RUN cycle 2 aborts: no done, outputs back to reset values
    drive(4, 32'h5555, 32'h4444, 1'b0, 1'b0, 1'b0, 34'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy",  64'(bus4.busy), 64'd0);
    check("abort_done",  64'(bus4.done), 64'd0);
    check("abort_res",   64'(bus4.res),  64'd0);
    check("abort_cout",  64'(bus4.cout), 64'd0);
    check("abort_err",   64'(bus4.err),  64'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Randomised, DIGITS=1
    for (int n = 0; n < 40; n++) begin
      ra = rand_bcd(1, n > 30); rb = rand_bcd(1, 1'b0);
      rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      drive(1, ra, rb, rs, rc, 1'b1, model(1, ra, rb, rs, rc));
      wait_drain(1);
    end

    // Randomised, DIGITS=8
    for (int n = 0; n < 40; n++) begin
      ra = rand_bcd(8, 1'b1); rb = rand_bcd(8, n > 30);
      rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      drive(8, ra, rb, rs, rc, 1'b1, model(8, ra, rb, rs, rc));
      wait_drain(8);
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_addsub_serial.md
# bcd_addsub_serial

Parametrised digit-serial BCD adder/subtractor, successor to the single-digit 4-bit decimal adder. It operates on DIGITS packed BCD digits, processing one digit per clock from least significant upward, with start/busy/done handshaking. It adds ten's-complement subtraction and invalid-digit detection, and is used wherever multi-digit decimal arithmetic can trade latency for area.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1); data width W = 4*DIGITS
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only in IDLE
- sub  in  1  0 = add, 1 = subtract; latched on accepted start
- a  in  W  operand A, packed BCD, digit 0 in a[3:0]; latched on accepted start
- b  in  W  operand B, packed BCD; latched on accepted start
- cin  in  1  add: carry-in; sub: borrow-in; latched on accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle completion pulse
- res  out  W  packed BCD result, registered, updated only at completion
- cout  out  1  add: decimal carry-out; sub: borrow-out
- err  out  1  latched operands held a digit >9; updated only at completion

## Operation
- States: IDLE, RUN.
- IDLE: start=1 → latch a, b, sub, cin; idx=0; carry = cin (add) or ~cin (sub); go RUN.
- RUN, per cycle, digit i=idx: bd = b_i (add) or 9−b_i (sub); s = a_i + bd + carry (5-bit, 0..19).
  - s>9 → digit = s−10, carry=1; otherwise digit = s, carry=0.
  - Digit written to internal working register position i; idx increments.
- Final digit (idx = DIGITS−1): res ← working register, including this digit.
  - cout ← carry (add) or ~carry (sub).
  - err ← OR over all latched digits of (digit > 9).
  - If err=1: res ← 0, cout ← 0.
  - done=1, go IDLE.
- Subtract result = (A − B − cin) mod 10^DIGITS (ten's complement); cout=1 ⇔ A < B + cin.
- start while busy is ignored; no queuing.
- res/cout/err hold their values between completions.
- Input changes after the start edge have no effect on the operation in flight.

## Timing
- Reset values: state IDLE, busy=0, done=0, res=0, cout=0, err=0, idx=0.
- Edge E0 samples start → busy=1 from E0.
- Edges E1..E_DIGITS process digits 0..DIGITS−1.
- At E_DIGITS: res/cout/err valid, done=1, busy=0. Latency = DIGITS cycles from the accepting edge to done.
- done is high for exactly one cycle. start high in the done cycle is accepted (state is IDLE), giving back-to-back throughput of one operation per DIGITS+1 cycles.
- DIGITS=1: done one cycle after start.
- rst=1 in RUN aborts the operation: no done pulse, outputs return to reset values at that edge. rst has priority over start.
- Carry-in of digit i is the registered carry from digit i−1; no combinational path from inputs to outputs.

## Test plan
- DIGITS=4 add: a=0x1234, b=0x8766, cin=0 → 4 cycles later done=1, res=0x0000, cout=1, err=0; busy high for exactly 4 cycles.
- Add with carry chain: a=0x0999, b=0x0001, cin=1 → res=0x1001, cout=0. a=0x9999, b=0x9999, cin=1 → res=0x9999, cout=1.
- Subtract: a=0x0500, b=0x0123, sub=1, cin=0 → res=0x0377, cout=0. Same with cin=1 → 0x0376. a=0x0123, b=0x0500 → res=0x9623, cout=1.
- Invalid digit: a=0x12A4, b=0x0001 → err=1, res=0x0000, cout=0. Next valid operation clears err.
- Handshake and reset:
  - start pulsed at cycles 1 and 2 of RUN → ignored; only one done.
  - start held in the done cycle → second operation starts, done again 4 cycles later.
  - rst at cycle 2 of RUN → no done; all outputs are 0 next cycle.
- Randomised, DIGITS=1 and DIGITS=8, valid BCD operands, random sub/cin → res/cout match a decimal reference model; done latency is always DIGITS.
